// File: rtl/iir_pkg.sv
// Shared types and helpers for the time-multiplexed biquad cascade.
package iir_pkg;

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_WB, S_OUT} state_t;
  typedef enum logic [2:0] {B0, B1, B2, A1, A2} tap_t;

  localparam int unsigned N_TAPS = 5;

  function automatic int unsigned coef_aw(input int unsigned n_sec);
    return (N_TAPS * n_sec > 1) ? $clog2(N_TAPS * n_sec) : 1;
  endfunction

  // Passthrough section: b0 = 1.0, everything else 0.
  function automatic logic [31:0] pass_coef(input int unsigned tap, input int unsigned frac);
    return (tap == 0) ? (32'd1 << frac) : 32'd0;
  endfunction

endpackage

// File: rtl/iir_mac_sat.sv
// Registered multiply, load/add accumulator, round-half-up shift and saturate.
module iir_mac_sat #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int ACC_W     = 36
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     mul_en_i,
  input  logic                     first_i,
  input  logic                     neg_i,
  input  logic signed [DATA_W-1:0] data_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic signed [DATA_W-1:0] y_o,
  output logic                     sat_o
);

  localparam int PW = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [PW-1:0]    prod_q;
  logic                    vld_q, first_q, neg_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] prod_ext, term, rnd, shf;

  assign prod_ext = ACC_W'(prod_q);
  assign term     = neg_q ? -prod_ext : prod_ext;

  // The product stage carries its own valid/first flags one cycle behind the tap.
  always_comb begin
    acc_d = acc_q;
    if (vld_q) acc_d = first_q ? term : acc_q + term;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prod_q  <= '0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      if (mul_en_i) prod_q <= PW'(data_i) * PW'(coef_i);
      vld_q   <= mul_en_i;
      first_q <= first_i;
      neg_q   <= neg_i;
      acc_q   <= acc_d;
    end
  end

  assign rnd = acc_q + HALF;
  assign shf = rnd >>> COEF_FRAC;

  always_comb begin
    sat_o = 1'b0;
    y_o   = DATA_W'(shf);
    if (shf > MAXV) begin
      sat_o = 1'b1;
      y_o   = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shf < MINV) begin
      sat_o = 1'b1;
      y_o   = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end

endmodule

// File: rtl/iir_biquad_cascade_mux.sv
// Multi-channel DF-I biquad cascade sharing one MAC; 7 cycles per section plus one output cycle.
module iir_biquad_cascade_mux
  import iir_pkg::*;
#(
  parameter  int DATA_W     = 16,
  parameter  int COEF_W     = 16,
  parameter  int COEF_FRAC  = 14,
  parameter  int N_SECTIONS = 4,
  parameter  int N_CHANNELS = 2,
  parameter  int ACC_W      = 36,
  localparam int CH_W       = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
  localparam int AW         = coef_aw(N_SECTIONS)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              sample_valid_i,
  input  logic [CH_W-1:0]   sample_ch_i,
  input  logic [DATA_W-1:0] sample_in_i,
  input  logic              bypass_i,
  input  logic              coef_wr_en_i,
  input  logic [AW-1:0]     coef_wr_addr_i,
  input  logic [COEF_W-1:0] coef_wr_data_i,
  input  logic              coef_commit_i,
  output logic              out_valid_o,
  output logic [CH_W-1:0]   out_ch_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              busy_o,
  output logic              overrun_o,
  output logic              sat_o
);

  localparam int NC = N_TAPS * N_SECTIONS;
  localparam int NH = N_CHANNELS * N_SECTIONS;
  localparam int HW = (NH > 1) ? $clog2(NH) : 1;
  localparam int SW = (N_SECTIONS > 1) ? $clog2(N_SECTIONS) : 1;

  typedef struct packed {
    logic [CH_W-1:0]          ch;
    logic                     byp;
    logic signed [DATA_W-1:0] x;
  } req_t;

  state_t                   state_q, state_d;
  tap_t                     tap_q;
  logic [SW-1:0]            sect_q;
  req_t                     req_q;
  logic signed [DATA_W-1:0] x_q;
  logic                     sat_acc_q, commit_pend_q;

  logic [COEF_W-1:0]        coef_act_q [NC];
  logic [COEF_W-1:0]        coef_shd_q [NC];
  logic [COEF_W-1:0]        coef_shd_d [NC];
  // Per channel/section history: 0=x1, 1=x2, 2=y1, 3=y2.
  logic signed [DATA_W-1:0] hist_q [NH][4];

  logic                     out_valid_q, overrun_q, sat_q;
  logic [CH_W-1:0]          out_ch_q;
  logic [DATA_W-1:0]        out_data_q;

  logic                     ch_ok, accept, last_sect;
  logic                     mac_en, mac_first, mac_neg, wb_en, out_fire, busy;
  logic [HW-1:0]            hidx;
  logic [AW-1:0]            caddr;
  logic signed [DATA_W-1:0] mac_data, mac_y;
  logic signed [COEF_W-1:0] mac_coef;
  logic                     mac_sat;

  assign ch_ok     = {1'b0, sample_ch_i} < (CH_W+1)'(N_CHANNELS);
  assign accept    = (state_q == S_IDLE) && sample_valid_i && ch_ok;
  assign last_sect = sect_q == SW'(N_SECTIONS - 1);

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_MAC;
      S_MAC:   if (tap_q == A2) state_d = S_DRAIN;
      S_DRAIN: state_d = S_WB;
      S_WB:    state_d = last_sect ? S_OUT : S_MAC;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mac_en   = 1'b0;
    wb_en    = 1'b0;
    out_fire = 1'b0;
    busy     = 1'b1;
    case (state_q)
      S_IDLE:  busy     = 1'b0;
      S_MAC:   mac_en   = 1'b1;
      S_WB:    wb_en    = 1'b1;
      S_OUT:   out_fire = 1'b1;
      default: ;
    endcase
  end

  assign mac_first = tap_q == B0;
  assign mac_neg   = (tap_q == A1) || (tap_q == A2);

  always_comb begin
    hidx     = HW'(int'(req_q.ch) * N_SECTIONS + int'(sect_q));
    caddr    = AW'(int'(sect_q) * N_TAPS + int'(tap_q));
    mac_coef = coef_act_q[caddr];
    case (tap_q)
      B1:      mac_data = hist_q[hidx][0];
      B2:      mac_data = hist_q[hidx][1];
      A1:      mac_data = hist_q[hidx][2];
      A2:      mac_data = hist_q[hidx][3];
      default: mac_data = x_q;
    endcase
  end

  // The shadow write is visible to a copy happening in the same cycle.
  always_comb begin
    coef_shd_d = coef_shd_q;
    if (coef_wr_en_i && ({1'b0, coef_wr_addr_i} < (AW+1)'(NC)))
      coef_shd_d[coef_wr_addr_i] = coef_wr_data_i;
  end

  iir_mac_sat #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .COEF_FRAC(COEF_FRAC),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .mul_en_i(mac_en),
    .first_i (mac_first),
    .neg_i   (mac_neg),
    .data_i  (mac_data),
    .coef_i  (mac_coef),
    .y_o     (mac_y),
    .sat_o   (mac_sat)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tap_q         <= B0;
      sect_q        <= '0;
      req_q         <= '0;
      x_q           <= '0;
      sat_acc_q     <= 1'b0;
      commit_pend_q <= 1'b0;
      out_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      sat_q         <= 1'b0;
      out_ch_q      <= '0;
      out_data_q    <= '0;
      for (int i = 0; i < NC; i++) begin
        coef_act_q[i] <= COEF_W'(pass_coef(i % N_TAPS, COEF_FRAC));
        coef_shd_q[i] <= COEF_W'(pass_coef(i % N_TAPS, COEF_FRAC));
      end
      for (int h = 0; h < NH; h++)
        for (int k = 0; k < 4; k++) hist_q[h][k] <= '0;
    end else begin
      coef_shd_q    <= coef_shd_d;
      commit_pend_q <= coef_commit_i | (commit_pend_q & ~accept);
      out_valid_q   <= out_fire;
      sat_q         <= out_fire & sat_acc_q & ~req_q.byp;
      overrun_q     <= sample_valid_i & ch_ok & busy;

      if (accept) begin
        req_q.ch  <= sample_ch_i;
        req_q.byp <= bypass_i;
        req_q.x   <= sample_in_i;
        x_q       <= sample_in_i;
        tap_q     <= B0;
        sect_q    <= '0;
        sat_acc_q <= 1'b0;
        if (commit_pend_q) coef_act_q <= coef_shd_d;
      end

      if (mac_en) tap_q <= (tap_q == A2) ? B0 : tap_t'(tap_q + 3'd1);

      if (wb_en) begin
        x_q    <= mac_y;
        sect_q <= sect_q + 1'b1;
        if (!req_q.byp) begin
          sat_acc_q       <= sat_acc_q | mac_sat;
          hist_q[hidx][1] <= hist_q[hidx][0];
          hist_q[hidx][0] <= x_q;
          hist_q[hidx][3] <= hist_q[hidx][2];
          hist_q[hidx][2] <= mac_y;
        end
      end

      if (out_fire) begin
        out_data_q <= req_q.byp ? req_q.x : x_q;
        out_ch_q   <= req_q.ch;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_ch_o    = out_ch_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = busy;
  assign overrun_o   = overrun_q;
  assign sat_o       = sat_q;

endmodule
